// File: rtl/cc_pkg.sv
// Shared types and constants for the sample pacer and its FIFO.
package cc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } pacer_state_e;

   localparam int unsigned DEFAULT_PERIOD = 251;
   localparam int unsigned FPF            = 11;

endpackage

// File: rtl/cc_sync_fifo.sv
// Single-clock FIFO with synchronous flush; storage is deliberately left unreset.
module cc_sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_push && do_pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/sample_pacer.sv
// Mixes multichannel input down to one sample and releases it at a fixed cadence.
// Optional SAMPLE_PACER_STATS_EN adds underrun and drop counters.
module sample_pacer
   import cc_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 1,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned PERIOD   = DEFAULT_PERIOD
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [CHANNELS*WIDTH-1:0]   inData,
   input  logic                        inValid,
   output logic                        inReady,
   output logic signed [WIDTH-1:0]     inputSample,
   output logic                        sampleReady,
   output logic                        primed
`ifdef SAMPLE_PACER_STATS_EN
   ,
   output logic [15:0]                 underrunCount,
   output logic [15:0]                 dropCount
`endif
);

   localparam int unsigned LOG2C = $clog2(CHANNELS);
   localparam int unsigned SW    = WIDTH + LOG2C;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned NW    = AW + 1;
   localparam int unsigned PW    = $clog2(PERIOD);

   pacer_state_e      state_q, state_d;
   logic [PW-1:0]     per_cnt_q, per_cnt_d;
   logic [WIDTH-1:0]  sample_q, sample_d;
   logic              strobe_q, strobe_d;

   logic signed [SW-1:0] mix_sum_c;
   logic [WIDTH-1:0]     mix_c;
   logic                 in_ready_c, in_xfer_c, tick_c, pop_c, underrun_c;
   logic [WIDTH-1:0]     fifo_rd_data;
   logic [NW-1:0]        fifo_count;
   logic                 fifo_full, fifo_empty;

   // Widened sum cannot overflow; arithmetic shift gives the floored mean
   always_comb begin
      mix_sum_c = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         mix_sum_c = mix_sum_c + SW'($signed(inData[k*WIDTH +: WIDTH]));
      end
      mix_c = WIDTH'(mix_sum_c >>> LOG2C);
   end

   assign in_ready_c = enable && !fifo_full && !rst;
   assign in_xfer_c  = inValid && in_ready_c;
   assign tick_c     = (state_q == RUN) && enable && (per_cnt_q == PW'(PERIOD - 1));
   assign pop_c      = tick_c && !fifo_empty;
   assign underrun_c = tick_c && fifo_empty;

   cc_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (!enable),
      .push      (in_xfer_c),
      .push_data (mix_c),
      .pop       (pop_c),
      .pop_data  (fifo_rd_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      per_cnt_d = '0;
      sample_d  = sample_q;
      strobe_d  = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = PRIME;
            PRIME:   if (fifo_count >= NW'(DEPTH / 2)) state_d = RUN;
            RUN:     if (underrun_c) state_d = PRIME;
            default: state_d = IDLE;
         endcase
      end
      // Counter only advances while staying in RUN; a tick wraps it
      if ((state_q == RUN) && enable && !tick_c) per_cnt_d = per_cnt_q + PW'(1);
      if (pop_c) begin
         sample_d = fifo_rd_data;
         strobe_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         per_cnt_q <= '0;
         sample_q  <= '0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_cnt_q <= per_cnt_d;
         sample_q  <= sample_d;
         strobe_q  <= strobe_d;
      end
   end

   assign inReady     = in_ready_c;
   assign inputSample = sample_q;
   assign sampleReady = strobe_q;
   assign primed      = (state_q == RUN);

`ifdef SAMPLE_PACER_STATS_EN
   logic [15:0] under_q, under_d;
   logic [15:0] drop_q, drop_d;

   always_comb begin
      under_d = under_q;
      drop_d  = drop_q;
      if (underrun_c && (under_q != 16'hFFFF)) under_d = under_q + 16'd1;
      if (enable && inValid && !in_ready_c && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         under_q <= '0;
         drop_q  <= '0;
      end else begin
         under_q <= under_d;
         drop_q  <= drop_d;
      end
   end

   assign underrunCount = under_q;
   assign dropCount     = drop_q;
`endif

endmodule

// File: tb/tb_sample_pacer.sv
// Self-checking bench for sample_pacer: queue-based reference model plus scenario tasks.
module tb_sample_pacer;

   localparam int W = 16;
   localparam int C = 2;
   localparam int D = 16;
   localparam int P = 251;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               enable = 1'b0;
   logic               inValid = 1'b0;
   logic [C*W-1:0]     inData = '0;
   logic               inReady;
   logic signed [W-1:0] inputSample;
   logic               sampleReady;
   logic               primed;
`ifdef SAMPLE_PACER_STATS_EN
   logic [15:0]        underrunCount;
   logic [15:0]        dropCount;
`endif

   sample_pacer #(
      .WIDTH    (W),
      .CHANNELS (C),
      .DEPTH    (D),
      .PERIOD   (P)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .inData      (inData),
      .inValid     (inValid),
      .inReady     (inReady),
      .inputSample (inputSample),
      .sampleReady (sampleReady),
      .primed      (primed)
`ifdef SAMPLE_PACER_STATS_EN
      ,
      .underrunCount (underrunCount),
      .dropCount     (dropCount)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Floored mean of the two signed channels, by plain integer arithmetic
   function automatic logic [15:0] ref_mix(input logic [31:0] d);
      logic [15:0] lo, hi;
      int a, b, s;
      lo = d[15:0];
      hi = d[31:16];
      a = int'($signed(lo));
      b = int'($signed(hi));
      s = a + b;
      if (s < 0 && (s % 2) != 0) return 16'((s - 1) / 2);
      return 16'(s / 2);
   endfunction

   // Reference model: 0 = idle, 1 = priming, 2 = running
   logic [15:0] mq[$];
   int          m_mode = 0;
   int          m_cnt = 0;
   logic        m_strobe = 1'b0;
   logic [15:0] m_sample = '0;
   int          m_under = 0;
   int          m_drop = 0;
   int          m_nstrobe = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_mode = 0; m_cnt = 0; m_strobe = 1'b0; m_sample = '0; m_under = 0; m_drop = 0;
      end else begin
         automatic int sz   = mq.size();
         automatic bit rdy  = enable && (sz < D);
         automatic bit tick = (m_mode == 2) && enable && (m_cnt == P - 1);
         m_strobe = 1'b0;
         if (!enable) begin
            mq.delete();
            m_mode = 0;
            m_cnt  = 0;
         end else begin
            if (inValid && !rdy && m_drop < 65535) m_drop++;
            if (tick && sz > 0) begin
               m_sample = mq.pop_front();
               m_strobe = 1'b1;
               m_nstrobe++;
            end
            if (tick && sz == 0 && m_under < 65535) m_under++;
            if (inValid && rdy) mq.push_back(ref_mix(inData));
            m_cnt = (m_mode == 2 && !tick) ? m_cnt + 1 : 0;
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && sz >= D / 2) m_mode = 2;
            else if (m_mode == 2 && tick && sz == 0) m_mode = 1;
         end
      end
   end

   bit mon_en = 1'b0;

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (sampleReady !== m_strobe) begin
            errors++;
            $display("FAIL mon_strobe t=%0t got %b want %b", $time, sampleReady, m_strobe);
         end
         checks++;
         if (inputSample !== m_sample) begin
            errors++;
            $display("FAIL mon_sample t=%0t got %h want %h", $time, inputSample, m_sample);
         end
         checks++;
         if (primed !== (m_mode == 2)) begin
            errors++;
            $display("FAIL mon_primed t=%0t got %b want %b", $time, primed, (m_mode == 2));
         end
         checks++;
         if (inReady !== (enable && (mq.size() < D) && !rst)) begin
            errors++;
            $display("FAIL mon_inready t=%0t got %b want %b", $time, inReady,
                     (enable && (mq.size() < D) && !rst));
         end
`ifdef SAMPLE_PACER_STATS_EN
         checks++;
         if (underrunCount !== 16'(m_under) || dropCount !== 16'(m_drop)) begin
            errors++;
            $display("FAIL mon_stats t=%0t got %0d/%0d want %0d/%0d", $time,
                     underrunCount, dropCount, m_under, m_drop);
         end
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #3;
   endtask

   task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
      inData  = {b, a};
      inValid = 1'b1;
      cyc();
      inValid = 1'b0;
   endtask

   task automatic restart();
      enable = 1'b0;
      cyc();
      enable = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b1;
      cyc();
      cyc();
      checks++;
      if (inputSample !== 16'sd0 || sampleReady !== 1'b0 || primed !== 1'b0 || inReady !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got %h %b %b %b want 0 0 0 0", inputSample, sampleReady, primed, inReady);
      end
      enable = 1'b0;
      rst = 1'b0;
      mon_en = 1'b1;
      cyc();
   endtask

   task automatic test_stream();
      logic [15:0] vals[$];
      int          when[$];
      logic [15:0] first_new;
      logic [31:0] r;
      logic [15:0] got;
      bit          seen;
      enable = 1'b1;
      for (int i = 1; i <= 8; i++) push_pair(16'(i), 16'(i));
      for (int n = 0; n < 9 * P + 20; n++) begin
         cyc();
         if (sampleReady) begin
            vals.push_back(inputSample);
            when.push_back(n);
         end
      end
      checks++;
      if (vals.size() != 8) begin
         errors++;
         $display("FAIL stream_count got %0d want 8", vals.size());
      end
      for (int i = 0; i < vals.size() && i < 8; i++) begin
         checks++;
         if (vals[i] !== 16'(i + 1)) begin
            errors++;
            $display("FAIL stream_value[%0d] got %h want %h", i, vals[i], 16'(i + 1));
         end
         if (i > 0) begin
            checks++;
            if (when[i] - when[i-1] != P) begin
               errors++;
               $display("FAIL stream_spacing[%0d] got %0d want %0d", i, when[i] - when[i-1], P);
            end
         end
      end
      checks++;
      if (primed !== 1'b0) begin
         errors++;
         $display("FAIL underrun_primed got %b want 0", primed);
      end
`ifdef SAMPLE_PACER_STATS_EN
      checks++;
      if (underrunCount !== 16'd1) begin
         errors++;
         $display("FAIL underrun_count got %0d want 1", underrunCount);
      end
`endif
      r = $urandom;
      first_new = ref_mix(r);
      push_pair(r[15:0], r[31:16]);
      for (int i = 1; i < 8; i++) begin
         r = $urandom;
         push_pair(r[15:0], r[31:16]);
      end
      seen = 1'b0;
      got  = '0;
      for (int n = 0; n < P + 20 && !seen; n++) begin
         cyc();
         if (sampleReady) begin
            seen = 1'b1;
            got  = inputSample;
         end
      end
      checks++;
      if (!seen || got !== first_new || primed !== 1'b1) begin
         errors++;
         $display("FAIL resume_run seen %b got %h primed %b want %h primed 1", seen, got, primed, first_new);
      end
   endtask

   task automatic test_mix();
      logic [15:0] vals[$];
      logic [31:0] r;
      restart();
      push_pair(16'h7FFF, 16'h7FFF);
      push_pair(16'h8000, 16'h7FFF);
      for (int i = 0; i < 6; i++) begin
         r = $urandom;
         push_pair(r[15:0], r[31:16]);
      end
      for (int n = 0; n < 2 * P + 20; n++) begin
         cyc();
         if (sampleReady) vals.push_back(inputSample);
      end
      checks++;
      if (vals.size() < 2 || vals[0] !== 16'h7FFF || vals[1] !== 16'hFFFF) begin
         errors++;
         $display("FAIL mix_values got n=%0d %h %h want 7fff ffff", vals.size(),
                  (vals.size() > 0) ? vals[0] : 16'h0, (vals.size() > 1) ? vals[1] : 16'h0);
      end
   endtask

   task automatic test_full();
      int d0;
      restart();
      d0 = 0;
`ifdef SAMPLE_PACER_STATS_EN
      d0 = int'(dropCount);
`endif
      inValid = 1'b1;
      for (int n = 0; n < 24; n++) begin
         inData = $urandom;
         cyc();
      end
      inValid = 1'b0;
      checks++;
      if (inReady !== 1'b0) begin
         errors++;
         $display("FAIL full_inready got %b want 0", inReady);
      end
`ifdef SAMPLE_PACER_STATS_EN
      checks++;
      if (int'(dropCount) - d0 != 8) begin
         errors++;
         $display("FAIL full_drops got %0d want 8", int'(dropCount) - d0);
      end
`endif
   endtask

   task automatic test_flush();
      logic [31:0] r;
      logic [15:0] first_new;
      logic [15:0] got;
      int          nstrobe;
      for (int n = 0; n < 50 && !primed; n++) cyc();
      repeat (20) cyc();
      enable = 1'b0;
      cyc();
      checks++;
      if (primed !== 1'b0 || inReady !== 1'b0) begin
         errors++;
         $display("FAIL flush_state got primed %b inReady %b want 0 0", primed, inReady);
      end
      enable = 1'b1;
      r = $urandom;
      first_new = ref_mix(r);
      push_pair(r[15:0], r[31:16]);
      for (int i = 1; i < 7; i++) begin
         r = $urandom;
         push_pair(r[15:0], r[31:16]);
      end
      nstrobe = 0;
      for (int n = 0; n < P + 50; n++) begin
         cyc();
         if (sampleReady) nstrobe++;
      end
      checks++;
      if (nstrobe != 0 || primed !== 1'b0) begin
         errors++;
         $display("FAIL flush_refill got %0d strobes primed %b want 0 0", nstrobe, primed);
      end
      r = $urandom;
      push_pair(r[15:0], r[31:16]);
      got = '0;
      for (int n = 0; n < P + 20; n++) begin
         cyc();
         if (sampleReady) begin
            nstrobe++;
            got = inputSample;
         end
      end
      checks++;
      if (nstrobe != 1 || got !== first_new) begin
         errors++;
         $display("FAIL flush_restart got %0d strobes value %h want 1 value %h", nstrobe, got, first_new);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      int          nstrobe;
      restart();
      for (int i = 0; i < 8; i++) begin
         r = $urandom;
         push_pair(r[15:0], r[31:16]);
      end
      nstrobe = 0;
      for (int n = 0; n < 4 * P && nstrobe < 3; n++) begin
         cyc();
         if (sampleReady) nstrobe++;
      end
      repeat (100) cyc();
      rst = 1'b1;
      #1;
      checks++;
      if (inputSample !== 16'sd0 || sampleReady !== 1'b0 || primed !== 1'b0 || inReady !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs got %h %b %b %b want 0 0 0 0", inputSample, sampleReady, primed, inReady);
      end
      cyc();
      rst = 1'b0;
      nstrobe = 0;
      for (int n = 0; n < 2 * P; n++) begin
         cyc();
         if (sampleReady) nstrobe++;
      end
      checks++;
      if (nstrobe != 0 || primed !== 1'b0) begin
         errors++;
         $display("FAIL midreset_after got %0d strobes primed %b want 0 0", nstrobe, primed);
      end
   endtask

   task automatic test_random();
      int seen;
      int base;
      restart();
      seen = 0;
      base = m_nstrobe;
      for (int n = 0; n < 3000; n++) begin
         inValid = ($urandom_range(0, 99) < ((n < 1200) ? 60 : 1));
         inData  = $urandom;
         if ($urandom_range(0, 799) == 0) enable = 1'b0;
         else enable = 1'b1;
         cyc();
         if (sampleReady) seen++;
      end
      inValid = 1'b0;
      checks++;
      if (seen != m_nstrobe - base) begin
         errors++;
         $display("FAIL random_strobes got %0d want %0d", seen, m_nstrobe - base);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_mix();
      test_full();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
